// File: rtl/d8m_raw_source.sv
// -----------------------------------------------------------------------------
// d8m_raw_source
// Synthetic D8M camera-port transmitter. Generates raw 10-bit GRBG Bayer test
// frames (colour bars, ramp, checkerboard, flat) on the same FVAL/LVAL/DATA
// interface the D8M capture path consumes, so the downstream chain can run
// without a sensor.
//
// Ports:
//   CCD_PIXCLK   in   1   pixel clock, all registers on its rising edge
//   RESET_SYS    in   1   synchronous active-high reset
//   ENABLE       in   1   run request, sampled only at frame boundaries
//   PATTERN_SEL  in   2   0 bars, 1 ramp, 2 checker, 3 flat (latched per frame)
//   FLAT_LEVEL   in  10   flat pattern value (latched per frame)
//   CCD_DATA     out 10   raw Bayer pixel, 0 outside LVAL
//   CCD_FVAL     out  1   frame valid
//   CCD_LVAL     out  1   line valid
//   FRAME_CNT    out 16   completed-frame count, wraps
//   FRAME_DONE   out  1   one-cycle pulse on the cycle FVAL falls
//   BUSY         out  1   high whenever the generator is not idle
//
// Optional feature macro: D8M_SRC_FRAME_STAMP_EN
//   When defined, pixel (0,0) of every frame carries FRAME_CNT[9:0].
//
// All outputs are registered from the current state, so every output lags
// the state register by one edge; this keeps LVAL and DATA aligned.
// -----------------------------------------------------------------------------
module d8m_raw_source #(
  parameter int H_ACTIVE   = 640,
  parameter int H_BLANK    = 152,
  parameter int V_ACTIVE   = 480,
  parameter int FV_LEAD    = 44,
  parameter int FV_TAIL    = 8,
  parameter int V_BLANK    = 800,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        CCD_PIXCLK,
  input  logic        RESET_SYS,
  input  logic        ENABLE,
  input  logic [1:0]  PATTERN_SEL,
  input  logic [9:0]  FLAT_LEVEL,
  output logic [9:0]  CCD_DATA,
  output logic        CCD_FVAL,
  output logic        CCD_LVAL,
  output logic [15:0] FRAME_CNT,
  output logic        FRAME_DONE,
  output logic        BUSY
);

  localparam logic [15:0] H_LAST    = 16'(H_ACTIVE - 1);
  localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
  localparam logic [15:0] V_LAST    = 16'(V_ACTIVE - 1);
  localparam logic [15:0] LEAD_LAST = 16'(FV_LEAD - 1);
  localparam logic [15:0] TAIL_LAST = 16'(FV_TAIL - 1);
  localparam logic [15:0] VB_LAST   = 16'(V_BLANK - 1);
  localparam logic [15:0] BAR_LAST  = 16'(H_ACTIVE / 8 - 1);

  // Bar b contains colour c when bit b of the colour's mask is set.
  // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0] BAR_R = 8'b0011_0011;
  localparam logic [7:0] BAR_G = 8'b0000_1111;
  localparam logic [7:0] BAR_B = 8'b0101_0101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_LINE = 3'd2,
    ST_HBL  = 3'd3,
    ST_TAIL = 3'd4,
    ST_VBL  = 3'd5
  } state_t;

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [15:0] x_r;
  logic [15:0] y_r;
  logic [15:0] bar_cnt_r;
  logic [2:0]  bar_idx_r;
  logic [1:0]  pat_sel_r;
  logic [9:0]  flat_r;
  logic [9:0]  data_r;
  logic        fval_r;
  logic        lval_r;
  logic [15:0] frame_cnt_r;
  logic        frame_done_r;
  logic        busy_r;
  logic [9:0]  pix_s;
  logic [9:0]  pix_out_s;

  // GRBG site lookup: even rows G/R, odd rows B/G.
  function automatic logic bar_on(input logic [2:0] idx, input logic x0, input logic y0);
    logic hit;
    case ({y0, x0})
      2'b00:   hit = BAR_G[idx];
      2'b01:   hit = BAR_R[idx];
      2'b10:   hit = BAR_B[idx];
      2'b11:   hit = BAR_G[idx];
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Pattern value for the current (X, Y) position
  always_comb begin
    pix_s = 10'd0;
    case (pat_sel_r)
      2'd0:    pix_s = bar_on(bar_idx_r, x_r[0], y_r[0]) ? 10'd1023 : 10'd0;
      2'd1:    pix_s = x_r[9:0];
      2'd2:    pix_s = (x_r[CHECK_LOG2] ^ y_r[CHECK_LOG2]) ? 10'd1023 : 10'd0;
      2'd3:    pix_s = flat_r;
      default: pix_s = 10'd0;
    endcase
  end

`ifdef D8M_SRC_FRAME_STAMP_EN
  // First pixel of the frame carries the completed-frame count
  always_comb begin
    pix_out_s = pix_s;
    if ((x_r == 16'd0) && (y_r == 16'd0)) begin
      pix_out_s = frame_cnt_r[9:0];
    end else begin
      pix_out_s = pix_s;
    end
  end
`else
  // Pattern value passes straight through
  always_comb begin
    pix_out_s = pix_s;
  end
`endif

  // Frame timing state machine, counters and registered outputs
  always_ff @(posedge CCD_PIXCLK) begin
    if (RESET_SYS) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 16'd0;
      x_r          <= 16'd0;
      y_r          <= 16'd0;
      bar_cnt_r    <= 16'd0;
      bar_idx_r    <= 3'd0;
      pat_sel_r    <= 2'd0;
      flat_r       <= 10'd0;
      data_r       <= 10'd0;
      fval_r       <= 1'b0;
      lval_r       <= 1'b0;
      frame_cnt_r  <= 16'd0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      fval_r       <= (state_r == ST_LEAD) || (state_r == ST_LINE) ||
                      (state_r == ST_HBL)  || (state_r == ST_TAIL);
      lval_r       <= (state_r == ST_LINE);
      busy_r       <= (state_r != ST_IDLE);
      data_r       <= (state_r == ST_LINE) ? pix_out_s : 10'd0;
      // The first VBL cycle is the edge on which FVAL falls.
      frame_done_r <= (state_r == ST_VBL) && (cnt_r == 16'd0);
      if ((state_r == ST_VBL) && (cnt_r == 16'd0)) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end

      case (state_r)
        ST_IDLE: begin
          if (ENABLE) begin
            pat_sel_r <= PATTERN_SEL;
            flat_r    <= FLAT_LEVEL;
            x_r       <= 16'd0;
            y_r       <= 16'd0;
            cnt_r     <= 16'd0;
            bar_cnt_r <= 16'd0;
            bar_idx_r <= 3'd0;
            state_r   <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (cnt_r == LEAD_LAST) begin
            cnt_r   <= 16'd0;
            state_r <= ST_LINE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_LINE: begin
          // Bar index advances every H_ACTIVE/8 pixels; it wraps back to 0
          // exactly at the end of the line.
          if (bar_cnt_r == BAR_LAST) begin
            bar_cnt_r <= 16'd0;
            bar_idx_r <= bar_idx_r + 3'd1;
          end else begin
            bar_cnt_r <= bar_cnt_r + 16'd1;
          end
          if (x_r == H_LAST) begin
            state_r <= ST_HBL;
          end else begin
            x_r <= x_r + 16'd1;
          end
        end
        ST_HBL: begin
          if (cnt_r == HB_LAST) begin
            cnt_r   <= 16'd0;
            x_r     <= 16'd0;
            y_r     <= y_r + 16'd1;
            state_r <= (y_r == V_LAST) ? ST_TAIL : ST_LINE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_TAIL: begin
          if (cnt_r == TAIL_LAST) begin
            cnt_r   <= 16'd0;
            state_r <= ST_VBL;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_VBL: begin
          if (cnt_r == VB_LAST) begin
            cnt_r <= 16'd0;
            if (ENABLE) begin
              pat_sel_r <= PATTERN_SEL;
              flat_r    <= FLAT_LEVEL;
              x_r       <= 16'd0;
              y_r       <= 16'd0;
              bar_cnt_r <= 16'd0;
              bar_idx_r <= 3'd0;
              state_r   <= ST_LEAD;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          cnt_r   <= 16'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign CCD_DATA   = data_r;
  assign CCD_FVAL   = fval_r;
  assign CCD_LVAL   = lval_r;
  assign FRAME_CNT  = frame_cnt_r;
  assign FRAME_DONE = frame_done_r;
  assign BUSY       = busy_r;

endmodule

// File: tb/tb_d8m_raw_source.sv
// -----------------------------------------------------------------------------
// tb_d8m_raw_source
// Directed self-checking bench for d8m_raw_source with a small frame geometry
// (16x4 active, 4 HBL, 3 lead, 2 tail, 5 VBL -> 85 FVAL-high + 5 low cycles).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_d8m_raw_source;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [9:0]  flat_level;
  logic [9:0]  ccd_data;
  logic        ccd_fval;
  logic        ccd_lval;
  logic [15:0] frame_cnt;
  logic        frame_done;
  logic        busy;

  int total;
  int bad;

  // capture results for one frame
  int         cap_hi;
  int         cap_lo;
  int         cap_lo_busy;
  int         cap_lines;
  int         cap_done_cnt;
  int         cap_outside;
  bit         cap_done_at_fall;
  bit         cap_next_rise;
  int         cap_len [0:3];
  logic [9:0] cap_pix [0:3][0:15];

  int bars_even [0:15] = '{1023, 1023, 1023, 1023, 1023, 0, 1023, 0,
                           0, 1023, 0, 1023, 0, 0, 0, 0};
  int bars_odd  [0:15] = '{1023, 1023, 0, 1023, 1023, 1023, 0, 1023,
                           1023, 0, 0, 0, 1023, 0, 0, 0};

  d8m_raw_source #(
    .H_ACTIVE   (16),
    .H_BLANK    (4),
    .V_ACTIVE   (4),
    .FV_LEAD    (3),
    .FV_TAIL    (2),
    .V_BLANK    (5),
    .CHECK_LOG2 (2)
  ) dut (
    .CCD_PIXCLK  (clk),
    .RESET_SYS   (rst),
    .ENABLE      (enable),
    .PATTERN_SEL (pattern_sel),
    .FLAT_LEVEL  (flat_level),
    .CCD_DATA    (ccd_data),
    .CCD_FVAL    (ccd_fval),
    .CCD_LVAL    (ccd_lval),
    .FRAME_CNT   (frame_cnt),
    .FRAME_DONE  (frame_done),
    .BUSY        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
  endtask

  // Waits (bounded) for FVAL to be seen high at a falling edge.
  task automatic wait_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ccd_fval === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Records one frame starting at the falling edge where FVAL is first high,
  // through its low period up to the next rise (or a 20-cycle bound).
  task automatic capture_frame;
    int  x;
    logic lv_prev;
    cap_hi = 0; cap_lo = 0; cap_lo_busy = 0; cap_lines = 0;
    cap_done_cnt = 0; cap_outside = 0; cap_done_at_fall = 1'b0; cap_next_rise = 1'b0;
    for (int l = 0; l < 4; l++) begin
      cap_len[l] = 0;
      for (int p = 0; p < 16; p++) cap_pix[l][p] = 'x;
    end
    x = 0;
    lv_prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ccd_fval !== 1'b1) break;
      cap_hi++;
      if (frame_done === 1'b1) cap_done_cnt++;
      if (ccd_lval === 1'b1) begin
        if (cap_lines < 4 && x < 16) cap_pix[cap_lines][x] = ccd_data;
        x++;
      end else begin
        if (ccd_data !== 10'd0) cap_outside++;
        if (lv_prev === 1'b1) begin
          if (cap_lines < 4) cap_len[cap_lines] = x;
          cap_lines++;
          x = 0;
        end
      end
      lv_prev = ccd_lval;
      @(negedge clk);
    end
    cap_done_at_fall = (frame_done === 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (ccd_fval === 1'b1) begin
        cap_next_rise = 1'b1;
        break;
      end
      cap_lo++;
      if (busy === 1'b1) cap_lo_busy++;
      if (frame_done === 1'b1) cap_done_cnt++;
      if (ccd_data !== 10'd0 || ccd_lval !== 1'b0) cap_outside++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    pattern_sel = 2'd2;
    flat_level  = 10'h3FF;
    do_reset();
    @(negedge clk);
    total++;
    if (ccd_fval !== 1'b0 || ccd_lval !== 1'b0 || ccd_data !== 10'd0 ||
        frame_cnt !== 16'd0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got fval=%b lval=%b data=%0d cnt=%0d done=%b busy=%b exp all 0",
               ccd_fval, ccd_lval, ccd_data, frame_cnt, frame_done, busy);
    end
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0 || ccd_fval !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold got busy=%b fval=%b exp 0 0", busy, ccd_fval);
    end
  endtask

  task automatic test_ramp;
    logic [9:0] exp;
    do_reset();
    pattern_sel = 2'd1;
    enable      = 1'b1;
    @(negedge clk);
    total++;
    if (ccd_fval !== 1'b0) begin
      bad++; $display("FAIL startup_early got fval=%b exp 0", ccd_fval);
    end
    @(negedge clk);
    total++;
    if (ccd_fval !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL startup_fval got fval=%b busy=%b exp 1 1", ccd_fval, busy);
    end
    for (int f = 0; f < 3; f++) begin
      capture_frame();
      total++;
      if (cap_hi !== 85) begin bad++; $display("FAIL ramp_fval_hi f%0d got=%0d exp=85", f, cap_hi); end
      total++;
      if (cap_lo !== 5 || cap_next_rise !== 1'b1) begin
        bad++; $display("FAIL ramp_fval_lo f%0d got=%0d rise=%b exp=5 rise=1", f, cap_lo, cap_next_rise);
      end
      total++;
      if (cap_lo_busy !== 5) begin bad++; $display("FAIL back_to_back_busy f%0d got=%0d exp=5", f, cap_lo_busy); end
      total++;
      if (cap_lines !== 4) begin bad++; $display("FAIL ramp_lines f%0d got=%0d exp=4", f, cap_lines); end
      for (int l = 0; l < 4; l++) begin
        total++;
        if (cap_len[l] !== 16) begin bad++; $display("FAIL ramp_lval_len f%0d l%0d got=%0d exp=16", f, l, cap_len[l]); end
      end
      total++;
      if (cap_done_at_fall !== 1'b1 || cap_done_cnt !== 1) begin
        bad++; $display("FAIL ramp_frame_done f%0d got at_fall=%b count=%0d exp 1 1", f, cap_done_at_fall, cap_done_cnt);
      end
      total++;
      if (cap_outside !== 0) begin bad++; $display("FAIL ramp_data_outside f%0d got=%0d exp=0", f, cap_outside); end
      for (int y = 0; y < 4; y++) begin
        for (int x = 0; x < 16; x++) begin
          exp = 10'(x);
`ifdef D8M_SRC_FRAME_STAMP_EN
          if (x == 0 && y == 0) exp = 10'(f);
`endif
          total++;
          if (cap_pix[y][x] !== exp) begin
            bad++; $display("FAIL ramp_pix f%0d y%0d x%0d got=%0d exp=%0d", f, y, x, cap_pix[y][x], exp);
          end
        end
      end
    end
    total++;
    if (frame_cnt !== 16'd3) begin bad++; $display("FAIL ramp_frame_cnt got=%0d exp=3", frame_cnt); end
  endtask

  task automatic test_bars;
    bit ok;
    logic [9:0] exp;
    do_reset();
    pattern_sel = 2'd0;
    enable      = 1'b1;
    wait_rise(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bars_start got no fval exp fval=1"); end
    capture_frame();
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 16; x++) begin
        exp = (y % 2 == 0) ? 10'(bars_even[x]) : 10'(bars_odd[x]);
`ifdef D8M_SRC_FRAME_STAMP_EN
        if (x == 0 && y == 0) exp = 10'd0;
`endif
        total++;
        if (cap_pix[y][x] !== exp) begin
          bad++; $display("FAIL bars_pix y%0d x%0d got=%0d exp=%0d", y, x, cap_pix[y][x], exp);
        end
      end
    end
  endtask

  task automatic test_checker;
    bit ok;
    logic [9:0] exp;
    do_reset();
    pattern_sel = 2'd2;
    enable      = 1'b1;
    wait_rise(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL checker_start got no fval exp fval=1"); end
    capture_frame();
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 16; x++) begin
        exp = ((x / 4) % 2 == 1) ? 10'd1023 : 10'd0;
        total++;
        if (cap_pix[y][x] !== exp) begin
          bad++; $display("FAIL checker_pix y%0d x%0d got=%0d exp=%0d", y, x, cap_pix[y][x], exp);
        end
      end
    end
  endtask

  task automatic test_flat_latch;
    bit ok;
    logic [9:0] exp;
    do_reset();
    pattern_sel = 2'd3;
    flat_level  = 10'h155;
    enable      = 1'b1;
    wait_rise(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL flat_start got no fval exp fval=1"); end
    fork
      capture_frame();
      begin
        repeat (30) @(negedge clk);
        pattern_sel = 2'd1;
        flat_level  = 10'h2AA;
      end
    join
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 16; x++) begin
        exp = 10'h155;
`ifdef D8M_SRC_FRAME_STAMP_EN
        if (x == 0 && y == 0) exp = 10'd0;
`endif
        total++;
        if (cap_pix[y][x] !== exp) begin
          bad++; $display("FAIL flat_pix y%0d x%0d got=%0d exp=%0d", y, x, cap_pix[y][x], exp);
        end
      end
    end
    total++;
    if (cap_next_rise !== 1'b1) begin bad++; $display("FAIL flat_next_frame got rise=%b exp 1", cap_next_rise); end
    capture_frame();
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 16; x++) begin
        exp = 10'(x);
`ifdef D8M_SRC_FRAME_STAMP_EN
        if (x == 0 && y == 0) exp = 10'd1;
`endif
        total++;
        if (cap_pix[y][x] !== exp) begin
          bad++; $display("FAIL flat_next_pix y%0d x%0d got=%0d exp=%0d", y, x, cap_pix[y][x], exp);
        end
      end
    end
  endtask

  task automatic test_enable_drop;
    bit ok;
    do_reset();
    pattern_sel = 2'd1;
    enable      = 1'b1;
    wait_rise(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL drop_start got no fval exp fval=1"); end
    fork
      capture_frame();
      begin
        repeat (26) @(negedge clk);
        enable = 1'b0;
      end
    join
    total++;
    if (cap_lines !== 4 || cap_hi !== 85) begin
      bad++; $display("FAIL drop_frame_complete got lines=%0d hi=%0d exp 4 85", cap_lines, cap_hi);
    end
    total++;
    if (cap_lo_busy !== 5) begin bad++; $display("FAIL drop_vbl_len got=%0d exp=5", cap_lo_busy); end
    total++;
    if (cap_next_rise !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL drop_idle got rise=%b busy=%b exp 0 0", cap_next_rise, busy);
    end
    total++;
    if (frame_cnt !== 16'd1 || cap_done_cnt !== 1) begin
      bad++; $display("FAIL drop_frame_cnt got cnt=%0d done=%0d exp 1 1", frame_cnt, cap_done_cnt);
    end
  endtask

  task automatic test_reset_mid_line;
    bit ok;
    pattern_sel = 2'd1;
    enable      = 1'b1;
    wait_rise(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midreset_start got no fval exp fval=1"); end
    repeat (8) @(negedge clk);
    total++;
    if (ccd_lval !== 1'b1 || ccd_data !== 10'd5 || frame_cnt !== 16'd1) begin
      bad++; $display("FAIL midreset_pre got lval=%b data=%0d cnt=%0d exp 1 5 1", ccd_lval, ccd_data, frame_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ccd_fval !== 1'b0 || ccd_lval !== 1'b0 || ccd_data !== 10'd0 ||
        frame_cnt !== 16'd0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs got fval=%b lval=%b data=%0d cnt=%0d done=%b busy=%b exp all 0",
               ccd_fval, ccd_lval, ccd_data, frame_cnt, frame_done, busy);
    end
    rst    = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || ccd_fval !== 1'b0) begin
      bad++; $display("FAIL midreset_idle got busy=%b fval=%b exp 0 0", busy, ccd_fval);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    flat_level  = 10'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_ramp();
    test_bars();
    test_checker();
    test_flat_latch();
    test_enable_drop();
    test_reset_mid_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d8m_raw_source.md
# d8m_raw_source

Synthetic D8M camera-port transmitter. It drives the same raw parallel interface the D8M capture path consumes: 10-bit Bayer data, frame-valid, line-valid, and a pixel clock. It generates programmable test frames (colour bars, ramp, checkerboard, flat), so the capture, line-buffer and demosaic chain can be exercised on hardware and in simulation without a sensor. It sits in place of the camera header inputs and feeds `CCD_DATA`, `CCD_FVAL` and `CCD_LVAL` directly.

## Interface

Parameters:
- `H_ACTIVE`, 640: pixels per line (LVAL high cycles). Must be a multiple of 8 and ≥ 8.
- `H_BLANK`, 152: LVAL-low cycles after every line, including the last. Must be ≥ 1.
- `V_ACTIVE`, 480: lines per frame. Must be ≥ 2.
- `FV_LEAD`, 44: cycles with FVAL high and LVAL low before the first line. Must be ≥ 1.
- `FV_TAIL`, 8: cycles with FVAL high after the last `H_BLANK`. Must be ≥ 1.
- `V_BLANK`, 800: cycles with FVAL low between frames. Must be ≥ 1.
- `CHECK_LOG2`, 5: checkerboard square size is 2^`CHECK_LOG2` pixels.

Ports:
- `CCD_PIXCLK`  in  1  pixel clock; every register in the block is on its rising edge.
- `RESET_SYS`  in  1  synchronous, active-high reset.
- `ENABLE`  in  1  run request. Sampled only at frame boundaries.
- `PATTERN_SEL`  in  2  pattern select: 0 = bars, 1 = ramp, 2 = checker, 3 = flat. Latched at frame start.
- `FLAT_LEVEL`  in  10  value used by the flat pattern. Latched at frame start.
- `CCD_DATA`  out  10  raw Bayer pixel.
- `CCD_FVAL`  out  1  frame valid.
- `CCD_LVAL`  out  1  line valid.
- `FRAME_CNT`  out  16  completed-frame count. Wraps at 0xFFFF.
- `FRAME_DONE`  out  1  one-cycle pulse on the cycle FVAL falls.
- `BUSY`  out  1  high in every state except IDLE.

## Operation

State machine: IDLE → LEAD → LINE ↔ HBL → TAIL → VBL → (LEAD | IDLE).

- **IDLE.** All outputs low. If `ENABLE` is 1, latch `PATTERN_SEL` and `FLAT_LEVEL`, clear X and Y, and go to LEAD.
- **LEAD.** FVAL=1, LVAL=0 for `FV_LEAD` cycles, then go to LINE.
- **LINE.** LVAL=1 for `H_ACTIVE` cycles. X runs 0..`H_ACTIVE`-1, then go to HBL.
- **HBL.** LVAL=0 for `H_BLANK` cycles. At the end, clear X and increment Y. If Y was `V_ACTIVE`-1, go to TAIL; otherwise go to LINE.
- **TAIL.** FVAL=1 for `FV_TAIL` cycles, then go to VBL.
- **VBL.** FVAL=0 for `V_BLANK` cycles. At the end:
  - if `ENABLE` is 1, re-latch the pattern inputs and go to LEAD;
  - otherwise go to IDLE.
- Deasserting `ENABLE` mid-frame never truncates a frame. The current frame, including its VBL, always completes.
- X, Y and the state-length counters are 16 bits wide.

Bayer mosaic (GRBG):
- Even Y: G at even X, R at odd X.
- Odd Y: B at even X, G at odd X.

Patterns (value driven while LVAL=1):
- **Bars.** Bar index b = X / (`H_ACTIVE`/8), produced by a sub-counter, not a divider.
  - Colour order for b = 0..7: white, yellow, cyan, green, magenta, red, blue, black.
  - Output is 1023 if the bar contains the colour of the current Bayer site, else 0.
- **Ramp.** X[9:0]; wraps every 1024 pixels.
- **Checker.** 1023 if X[`CHECK_LOG2`] ^ Y[`CHECK_LOG2`] is 1, else 0.
- **Flat.** The latched `FLAT_LEVEL`.
- Outside LVAL=1, `CCD_DATA` is 0.

## Timing

- All outputs are registered. Reset value of every output is 0.
- Reset mid-frame: on the next edge all outputs are 0, the state is IDLE, and `FRAME_CNT` is 0.
- Start-up: `ENABLE`=1 sampled in IDLE at edge n gives `CCD_FVAL`=1 from edge n+1.
- `CCD_LVAL` and `CCD_DATA` for pixel X are valid on the same edge. Pixel-to-output latency is zero relative to LVAL.
- FVAL-high cycles per frame: `FV_LEAD` + `V_ACTIVE`·(`H_ACTIVE`+`H_BLANK`) + `FV_TAIL`.
- Frame period: the FVAL-high cycles + `V_BLANK`.
- `FRAME_DONE` and the `FRAME_CNT` increment occur on the first FVAL=0 edge.
- Back-to-back frames: there is no IDLE cycle between the last VBL cycle and the next LEAD.

## Configuration

Macro `D8M_SRC_FRAME_STAMP_EN`:
- **Defined:** pixel X=0, Y=0 of each frame carries `FRAME_CNT`[9:0] instead of the pattern value.
- **Undefined:** the pattern value is driven, and no stamp logic is built.

## Test plan

Bench parameters: `H_ACTIVE`=16, `H_BLANK`=4, `V_ACTIVE`=4, `FV_LEAD`=3, `FV_TAIL`=2, `V_BLANK`=5, `CHECK_LOG2`=2.

1. Ramp, `ENABLE` held 1 → FVAL high 85 cycles, low 5; 4 LVAL pulses of 16; data 0..15 on every line; `FRAME_DONE` every 90 cycles; `FRAME_CNT` = 3 after 270 cycles.
2. Bars → line 0 reads 1023,1023 (white, X 0–1), 1023,1023 (yellow), 1023,0 (cyan), 1023,0 (green), 0,1023 (magenta), 0,1023 (red), 0,0 (blue), 0,0 (black).
3. Checker → Y=0: X 0–3 = 0, X 4–7 = 1023, and so on; Y=1 is identical; Y=4 is unused (only 4 lines), so check that rows 0–3 match.
4. Flat, `FLAT_LEVEL`=0x155; `PATTERN_SEL` changed mid-frame → current frame stays 0x155 on all active pixels; the new pattern appears only from the next frame.
5. `ENABLE` dropped at line 1 → frame completes with 4 lines, VBL of 5 cycles, then IDLE with `BUSY`=0. `RESET_SYS` pulsed mid-line → all outputs 0 next edge.
6. With `D8M_SRC_FRAME_STAMP_EN`, ramp, three frames → pixel (0,0) reads 0, 1, 2 and all other pixels are unchanged.
